// File: rtl/serial_parity_checker.sv
// Receive-side serial deframer: start, DATA_W data bits (LSB first), parity, stop.
// Reports each frame's word with parity/framing status and keeps a saturating error count.
//
// state  | meaning
// IDLE   | waiting for a start bit (x=0) on an accepted edge
// DATA   | collecting data bits into the shift register
// PARITY | sampling the transmitted parity bit
// STOP   | sampling the stop bit, reporting the frame
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    input  logic              in_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              running_par,
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            case (state)
                IDLE:    if (!x) state_nxt = DATA;
                DATA:    if (bit_cnt == LAST_BIT) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_bad     <= 1'b0;
            running_par <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (!x) begin
                            bit_cnt     <= '0;
                            running_par <= 1'b0;
                            par_bad     <= 1'b0;
                        end
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bit_cnt == CNT_W'(i)) shift_reg[i] <= x;
                        end
                        running_par <= running_par ^ x;
                        bit_cnt     <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par_bad <= (x != (running_par ^ ODD_PARITY));
                    end
                    STOP: begin
                        // A low stop bit ends the frame; it is never taken as the next start bit.
                        if (x) begin
                            data_out   <= shift_reg;
                            data_valid <= 1'b1;
                            parity_err <= par_bad;
                            if (par_bad && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: frames are driven from one initial block,
// expected reports are queued at send time and matched when the DUT pulses.
module tb_serial_parity_checker;

    localparam int DATA_W = 8;
    localparam bit ODD    = 1'b0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              x = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              running_par;
    logic [7:0]        err_count;
    logic              busy;

    serial_parity_checker #(.DATA_W(DATA_W), .ODD_PARITY(ODD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .in_valid    (in_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .running_par (running_par),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       dv;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_dv_seen = 0;
    int         n_dv_exp = 0;
    int         err_model = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Inputs change 2 ns after a rising edge; the bit is sampled on the next edge.
    task automatic step(input logic b, input logic v);
        x        = b;
        in_valid = v;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                              input int st3, input int stp);
        exp_t e;
        logic p;
        logic rp;
        p      = (^d) ^ ODD ^ flip;
        e.at   = cyc + 11 + st3 + stp;
        e.dv   = stop;
        e.pe   = stop & flip;
        e.fe   = ~stop;
        e.data = stop ? d : last_good;
        if (stop) begin
            last_good = d;
            n_dv_exp++;
        end
        if ((flip || !stop) && err_model < 255) err_model++;
        sb.push_back(e);

        step(1'b0, 1'b1);
        chk("busy_start", busy, 1);
        chk("rpar_clear", running_par, 0);
        rp = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            step(d[i], 1'b1);
            rp ^= d[i];
            chk("rpar_bit", running_par, rp);
            if (i == 3) begin
                for (int s = 0; s < st3; s++) begin
                    step(~d[i], 1'b0);
                    chk("rpar_stall_data", running_par, rp);
                    chk("busy_stall", busy, 1);
                end
            end
        end
        step(p, 1'b1);
        for (int s = 0; s < stp; s++) begin
            step(~stop, 1'b0);
            chk("rpar_stall_par", running_par, rp);
        end
        step(stop, 1'b1);
        chk("busy_end", busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (data_valid || parity_err || frame_err)) begin
            if (data_valid) n_dv_seen++;
            if (sb.size() == 0) begin
                chk("pulse_unexpected", {data_valid, parity_err, frame_err}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_valid", data_valid, e.dv);
                chk("parity_err", parity_err, e.pe);
                chk("frame_err", frame_err, e.fe);
                chk("data_out", data_out, e.data);
                chk("report_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #12;
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_pulses", {data_valid, parity_err, frame_err, running_par}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        step(1'b1, 1'b1);

        // good 0xA5, then parity error, then framing error on 0x3C
        send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b1);
        chk("err_count_good", err_count, err_model);
        send_frame(8'hA5, 1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1);
        chk("err_count_par", err_count, err_model);
        send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1);
        chk("err_count_frame", err_count, err_model);
        chk("data_out_kept", data_out, 8'hA5);

        // stalls after d3 and in PARITY
        send_frame(8'hA5, 1'b0, 1'b1, 3, 2);
        step(1'b1, 1'b1);
        chk("err_count_stall", err_count, err_model);

        // reset in the middle of a frame
        step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(i[0], 1'b1);
        #1;
        rst_n = 1'b0;
        x = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pulses", {data_valid, parity_err, frame_err, running_par}, 0);
        last_good = 8'h00;
        err_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        send_frame(8'h5A, 1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b1);
        chk("err_count_after_rst", err_count, 0);
        chk("data_out_after_rst", data_out, 8'h5A);

        // back-to-back parity errors, counter saturates
        for (int f = 0; f < 256; f++) send_frame(8'(f * 37 + 11), 1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1);
        chk("err_count_sat", err_count, 255);
        chk("err_model_sat", err_count, err_model);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("sb_drained", sb.size(), 0);
        chk("dv_pulse_count", n_dv_seen, n_dv_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Receive-side counterpart of the serial parity generator. The block deserialises a framed bit stream, with one bit accepted per clock when `in_valid` is high. It recomputes parity across the data bits and compares it against the transmitted parity bit. It presents the assembled word with per-frame parity and framing status, and keeps a saturating error count. It sits between a serial link input and the word-level consumer logic.

## Interface
- `DATA_W`, default 8: number of data bits per frame (valid range 1–16).
- `ODD_PARITY`, default 0.
  - 0: even parity. Data bits plus parity bit must contain an even number of ones.
  - 1: odd parity.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `x` input 1: serial line bit. Idle level is 1.
- `in_valid` input 1: `x` is sampled only on edges where `in_valid`=1.
- `data_out` output DATA_W: last received word, LSB received first.
- `data_valid` output 1: one-cycle pulse when a frame completes with a good stop bit.
- `parity_err` output 1: one-cycle pulse, coincident with `data_valid`, when the parity check fails.
- `frame_err` output 1: one-cycle pulse when the stop bit is 0.
- `running_par` output 1: XOR of the data bits received so far in the current frame. Cleared at start-bit detection.
- `err_count` output 8: count of parity plus framing errors, saturating at 255.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Frame format, in line order: start(0), d0..d(DATA_W-1), parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
- **IDLE:**
  - On an accepted bit with `x`=0, go to DATA, clear the bit counter, and clear `running_par`.
  - On `x`=1, stay in IDLE.
- **DATA:**
  - Each accepted bit is shifted into the shift register at position `bit_cnt` (LSB first).
  - Each accepted bit is XORed into `running_par`.
  - `bit_cnt` increments. After bit DATA_W-1 is accepted, go to PARITY.
- **PARITY:**
  - The accepted bit is stored as `rx_par`.
  - Expected parity is `running_par ^ ODD_PARITY`.
  - Mismatch sets an internal `par_bad` flag. Go to STOP.
- **STOP:**
  - If the accepted bit is 1:
    - load `data_out` from the shift register;
    - pulse `data_valid`;
    - pulse `parity_err` = `par_bad`.
  - If the accepted bit is 0:
    - pulse `frame_err`;
    - `data_out` is unchanged;
    - no `data_valid` or `parity_err` pulse.
  - In both cases go to IDLE. A 0 stop bit is not reinterpreted as a new start bit.
- **Error counter:**
  - `err_count` increments by 1 when `parity_err` or `frame_err` pulses.
  - `parity_err` and `frame_err` are never asserted together.
  - At 255 the counter holds.
- **Stall:** with `in_valid`=0, the state, counter, shift register and `running_par` all hold, at any point in the frame.
- **Reset:** `rst_n`=0 at any time forces IDLE immediately, including mid-frame. The partial frame is discarded. Reset values:
  - `data_out` = 0
  - `data_valid` = `parity_err` = `frame_err` = 0
  - `running_par` = 0
  - `err_count` = 0
  - `busy` = 0

## Timing
- All outputs are registered and change only on the rising edge of `clk`, except on asynchronous reset.
- Latency:
  - `data_valid`, `parity_err` and `frame_err` go high on the same edge that samples the stop bit.
  - They are high for exactly one cycle, then low on the next edge regardless of `in_valid`.
- With continuous `in_valid`, a frame takes DATA_W+3 cycles. For DATA_W=8 this is 11 cycles.
- Back-to-back frames: a start bit may be accepted on the edge immediately after the stop-bit edge. No idle gap is required.
- `running_par` updates on the edge that accepts each data bit. It holds through PARITY and STOP, and clears on the next start-bit edge.
- `busy` rises on the start-bit edge and falls on the stop-bit edge.
- Testbench drives `x`/`in_valid` 2 ns after the clock edge (10 ns period) so inputs are stable before sampling.

## Test plan
- **Good frame:** DATA_W=8, even parity, `in_valid`=1. Send 0, then 1,0,1,0,0,1,0,1 (0xA5), parity 0, stop 1.
  - `data_out`=0xA5.
  - `data_valid`=1 for one cycle, 11 edges after the start.
  - `parity_err`=0, `err_count`=0.
- **Parity error:** same frame with parity bit 1.
  - `data_valid`=1, `parity_err`=1, `data_out`=0xA5, `err_count`=1.
- **Framing error:** 0x3C with correct parity 0 and stop bit 0.
  - `frame_err`=1, `data_valid`=0.
  - `data_out` keeps its previous value.
  - `err_count` increments.
  - `busy`=0 next cycle.
- **Stall:** 0xA5 frame with `in_valid` dropped for 3 cycles after d3 and for 2 cycles in PARITY.
  - Same result as the good frame, completing 5 cycles later.
  - `running_par` holds during the stalls.
- **Reset mid-frame:** assert `rst_n`=0 after d4, release, then send a full 0x5A frame with parity 0.
  - All outputs are 0 during reset.
  - Only the 0x5A frame is reported, with no error.
- **Saturation and back-to-back:** 256 consecutive parity-error frames with no idle gap.
  - `err_count` reaches 255 and holds.
  - Every frame produces exactly one `data_valid` pulse.
